s2qed_axil_lockstep_resp: RTL

//  Parametrised S2QED harness responder for NUM_INST identical core instances.

---
 rtl/s2qed_axil_lockstep_resp.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/s2qed_axil_lockstep_resp.sv
// ============================================================================
//  Module   : s2qed_axil_lockstep_resp
//  Purpose  : S2QED harness responder. One AXI4-Lite slave with a private
//             word memory per core instance; instance 0 transactions are
//             logged and every other instance is checked against that log
//             in order, with per-instance throttling to keep lockstep.
//  Options  : S2QED_DATA_CMP_EN - also compare write data/strobes and read
//             return data (default: type and word address only).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2qed_axil_lockstep_resp #(
    parameter int NUM_INST  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256,
    parameter int RD_LAT    = 1,
    parameter int LOG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INST-1:0]            awvalid,
    output logic [NUM_INST-1:0]            awready,
    input  logic [NUM_INST*ADDR_W-1:0]     awaddr,
    input  logic [NUM_INST-1:0]            wvalid,
    output logic [NUM_INST-1:0]            wready,
    input  logic [NUM_INST*DATA_W-1:0]     wdata,
    input  logic [NUM_INST*DATA_W/8-1:0]   wstrb,
    output logic [NUM_INST-1:0]            bvalid,
    input  logic [NUM_INST-1:0]            bready,
    input  logic [NUM_INST-1:0]            arvalid,
    output logic [NUM_INST-1:0]            arready,
    input  logic [NUM_INST*ADDR_W-1:0]     araddr,
    output logic [NUM_INST-1:0]            rvalid,
    input  logic [NUM_INST-1:0]            rready,
    output logic [NUM_INST*DATA_W-1:0]     rdata,
    output logic [NUM_INST-1:0]            mismatch_vec,
    output logic                           mismatch
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int LOG_AW = $clog2(LOG_DEPTH);
    localparam int PTR_W  = LOG_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_RESP, S_WR_RESP} state_t;

    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] s);
        for (int b = 0; b < STRB_W; b++) strb_mask[b*8 +: 8] = {8{s[b]}};
    endfunction

    logic [NUM_INST-1:0]        w_wr_acc, w_rd_acc, w_acc, w_permit, w_cap;
    logic [NUM_INST-1:0]        w_entry_mm, w_rdata_mm;
    logic [NUM_INST*DATA_W-1:0] w_rword;
    logic [NUM_INST-1:0]        r_mm;
    logic [PTR_W-1:0]           r_wp;
    logic [PTR_W-1:0]           r_rp [NUM_INST];
    logic [PTR_W-1:0]           w_occ [NUM_INST];
    logic                       r_log_wr  [LOG_DEPTH];
    logic [IDX_W-1:0]           r_log_idx [LOG_DEPTH];
    logic [IDX_W-1:0]           w_idx0;
`ifdef S2QED_DATA_CMP_EN
    logic [DATA_W-1:0]          r_log_data [LOG_DEPTH];
    logic [STRB_W-1:0]          r_log_strb [LOG_DEPTH];
    logic [LOG_AW-1:0]          r_slot [NUM_INST];
`endif

    assign w_acc        = w_wr_acc | w_rd_acc;
    assign mismatch_vec = r_mm;
    assign mismatch     = |r_mm;

    // ------------------------------------------------------------------
    // Per-instance AXI4-Lite responder with private memory
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_INST; i++) begin : g_inst
        state_t            r_state;
        logic [3:0]        r_cnt;
        logic [IDX_W-1:0]  r_ridx;
        logic              r_bvalid, r_rvalid;
        logic [DATA_W-1:0] r_rdata;
        logic [DATA_W-1:0] r_mem [MEM_WORDS];
        logic [IDX_W-1:0]  w_awidx, w_aridx;
        logic [DATA_W-1:0] w_mask, w_rd_word;

        assign w_awidx   = awaddr[i*ADDR_W+2 +: IDX_W];
        assign w_aridx   = araddr[i*ADDR_W+2 +: IDX_W];
        assign w_mask    = strb_mask(wstrb[i*STRB_W +: STRB_W]);
        // With single-cycle latency the data is sampled at the accept edge
        assign w_rd_word = r_mem[(RD_LAT == 1) ? w_aridx : r_ridx];

        assign w_wr_acc[i] = (r_state == S_IDLE) & awvalid[i] & wvalid[i] & w_permit[i];
        assign w_rd_acc[i] = (r_state == S_IDLE) & arvalid[i] & w_permit[i] & ~w_wr_acc[i];
        assign w_cap[i]    = (RD_LAT == 1) ? w_rd_acc[i]
                                           : ((r_state == S_RD_WAIT) && (r_cnt == 4'd1));
        assign w_rword[i*DATA_W +: DATA_W] = w_rd_word;

        assign awready[i] = w_wr_acc[i];
        assign wready[i]  = w_wr_acc[i];
        assign arready[i] = w_rd_acc[i];
        assign bvalid[i]  = r_bvalid;
        assign rvalid[i]  = r_rvalid;
        assign rdata[i*DATA_W +: DATA_W] = r_rdata;

        // Byte-masked memory update at write accept
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int w = 0; w < MEM_WORDS; w++) r_mem[w] <= '0;
            end else if (w_wr_acc[i]) begin
                r_mem[w_awidx] <= (r_mem[w_awidx] & ~w_mask)
                                | (wdata[i*DATA_W +: DATA_W] & w_mask);
            end
        end

        // Responder FSM: accept, latency count, hold response until ready
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_ridx   <= '0;
                r_bvalid <= 1'b0;
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_wr_acc[i]) begin
                            r_bvalid <= 1'b1;
                            r_state  <= S_WR_RESP;
                        end else if (w_rd_acc[i]) begin
                            r_ridx <= w_aridx;
                            if (RD_LAT == 1) begin
                                r_rdata  <= w_rd_word;
                                r_rvalid <= 1'b1;
                                r_state  <= S_RD_RESP;
                            end else begin
                                r_cnt   <= 4'(RD_LAT - 1);
                                r_state <= S_RD_WAIT;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_rdata  <= w_rd_word;
                            r_rvalid <= 1'b1;
                            r_state  <= S_RD_RESP;
                        end
                    end
                    S_RD_RESP: begin
                        if (rready[i]) begin
                            r_rvalid <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    S_WR_RESP: begin
                        if (bready[i]) begin
                            r_bvalid <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Occupancy per follower and lockstep throttling
    always_comb begin
        w_permit    = '0;
        w_permit[0] = 1'b1;
        w_occ[0]    = '0;
        for (int k = 1; k < NUM_INST; k++) begin
            w_occ[k] = r_wp - r_rp[k];
            if (w_occ[k] == PTR_W'(LOG_DEPTH)) w_permit[0] = 1'b0;
            w_permit[k] = (w_occ[k] != '0);
        end
    end

    // Compare each follower accept against the oldest unchecked log entry
    always_comb begin
        w_entry_mm = '0;
        for (int k = 1; k < NUM_INST; k++) begin
            logic [LOG_AW-1:0] slot;
            logic [IDX_W-1:0]  idx;
            slot = r_rp[k][LOG_AW-1:0];
            idx  = w_wr_acc[k] ? awaddr[k*ADDR_W+2 +: IDX_W] : araddr[k*ADDR_W+2 +: IDX_W];
            if ((r_log_wr[slot] != w_wr_acc[k]) || (r_log_idx[slot] != idx))
                w_entry_mm[k] = 1'b1;
`ifdef S2QED_DATA_CMP_EN
            if (w_wr_acc[k] && r_log_wr[slot] &&
                ((r_log_data[slot] != (wdata[k*DATA_W +: DATA_W] &
                                       strb_mask(wstrb[k*STRB_W +: STRB_W]))) ||
                 (r_log_strb[slot] != wstrb[k*STRB_W +: STRB_W])))
                w_entry_mm[k] = 1'b1;
`endif
        end
    end

    // Read return data check for followers, at the cycle rdata is captured
`ifdef S2QED_DATA_CMP_EN
    always_comb begin
        w_rdata_mm = '0;
        for (int k = 1; k < NUM_INST; k++) begin
            logic [LOG_AW-1:0] cslot;
            cslot = (RD_LAT == 1) ? r_rp[k][LOG_AW-1:0] : r_slot[k];
            if (w_cap[k] && (r_log_data[cslot] != w_rword[k*DATA_W +: DATA_W]))
                w_rdata_mm[k] = 1'b1;
        end
    end
`else
    assign w_rdata_mm = '0;
`endif

    // Log pointers and sticky mismatch flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_mm <= '0;
            for (int k = 0; k < NUM_INST; k++) r_rp[k] <= '0;
`ifdef S2QED_DATA_CMP_EN
            for (int k = 0; k < NUM_INST; k++) r_slot[k] <= '0;
`endif
        end else begin
            if (w_acc[0]) r_wp <= r_wp + 1'b1;
`ifdef S2QED_DATA_CMP_EN
            if (w_rd_acc[0]) r_slot[0] <= r_wp[LOG_AW-1:0];
`endif
            for (int k = 1; k < NUM_INST; k++) begin
                if (w_acc[k]) begin
                    r_rp[k] <= r_rp[k] + 1'b1;
                    if (w_entry_mm[k]) r_mm[k] <= 1'b1;
                end
                if (w_rdata_mm[k]) r_mm[k] <= 1'b1;
`ifdef S2QED_DATA_CMP_EN
                if (w_rd_acc[k]) r_slot[k] <= r_rp[k][LOG_AW-1:0];
`endif
            end
        end
    end

    assign w_idx0 = w_wr_acc[0] ? awaddr[2 +: IDX_W] : araddr[2 +: IDX_W];

    // Log storage written on every instance 0 accept (and at its read capture)
    always_ff @(posedge clk) begin
        if (w_acc[0]) begin
            r_log_wr[r_wp[LOG_AW-1:0]]  <= w_wr_acc[0];
            r_log_idx[r_wp[LOG_AW-1:0]] <= w_idx0;
`ifdef S2QED_DATA_CMP_EN
            r_log_strb[r_wp[LOG_AW-1:0]] <= w_wr_acc[0] ? wstrb[STRB_W-1:0] : '0;
            r_log_data[r_wp[LOG_AW-1:0]] <= w_wr_acc[0]
                ? (wdata[DATA_W-1:0] & strb_mask(wstrb[STRB_W-1:0]))
                : w_rword[DATA_W-1:0];
`endif
        end
`ifdef S2QED_DATA_CMP_EN
        if (w_cap[0] && !w_rd_acc[0]) r_log_data[r_slot[0]] <= w_rword[DATA_W-1:0];
`endif
    end

endmodule

`default_nettype wire
